// File: rtl/bus_datapath_if.sv
// Handshake, memory and status signals of the bus datapath.
// The master side offers micro-ops and answers memory requests; the slave side is the datapath.
interface bus_datapath_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 64
);
  localparam int RSEL = $clog2(NREGS);

  logic             uop_valid;
  logic             uop_ready;
  logic [1:0]       uop_op;
  logic [2:0]       uop_src;
  logic [2:0]       uop_dst;
  logic [2:0]       uop_alu;
  logic [RSEL-1:0]  uop_reg;
  logic [WIDTH-1:0] uop_imm;
  logic             uop_pcinc;

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  logic             done;
  logic             err;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] bus;

  modport master (
    output uop_valid, uop_op, uop_src, uop_dst, uop_alu, uop_reg, uop_imm, uop_pcinc,
    output mem_rdata, mem_ack,
    input  uop_ready, mem_req, mem_we, mem_addr, mem_wdata, done, err, pc, ir, bus
  );

  modport slave (
    input  uop_valid, uop_op, uop_src, uop_dst, uop_alu, uop_reg, uop_imm, uop_pcinc,
    input  mem_rdata, mem_ack,
    output uop_ready, mem_req, mem_we, mem_addr, mem_wdata, done, err, pc, ir, bus
  );
endinterface

// File: rtl/bus_datapath.sv
// Single-bus datapath executing MOVE / ALU / memory micro-ops through an
// IDLE -> EXEC|MEM -> DONE sequence, with a bounded wait on memory acknowledge.
module bus_datapath #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 64,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  bus_datapath_if.slave   io
);
  localparam int RSEL = $clog2(NREGS);
  localparam int CW   = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] WORD_ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] WORD_ONE  = WIDTH'(1);

  localparam logic [1:0] OP_MOVE  = 2'd0;
  localparam logic [1:0] OP_ALU   = 2'd1;
  localparam logic [1:0] OP_MEMRD = 2'd2;
  localparam logic [1:0] OP_MEMWR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] pc_r, ir_r, mar_r, mdr_r, x_r, y_r, z_r, bus_r;
  logic [WIDTH-1:0] rf_r [NREGS];

  logic [1:0]       op_r;
  logic [2:0]       src_r, dst_r, alu_r;
  logic [RSEL-1:0]  reg_r;
  logic [WIDTH-1:0] imm_r;
  logic             pcinc_r;
  logic [CW-1:0]    cnt_r;

  logic             ready_r, done_r, err_r, mem_req_r, mem_we_r;
  logic [WIDTH-1:0] mem_addr_r, mem_wdata_r;

  logic [WIDTH-1:0] src_val_s;
  logic             src_ok_s;
  logic [WIDTH-1:0] alu_s;
  logic [WIDTH-1:0] pc_inc_s;

  assign pc_inc_s = pc_r + WORD_ONE;

  // Bus source selection from the latched micro-op; code 7 flags an illegal source.
  always_comb begin
    src_val_s = WORD_ZERO;
    src_ok_s  = 1'b1;
    case (src_r)
      3'd0:    src_val_s = pc_r;
      3'd1:    src_val_s = mdr_r;
      3'd2:    src_val_s = z_r;
      3'd3:    src_val_s = rf_r[reg_r];
      3'd4:    src_val_s = x_r;
      3'd5:    src_val_s = y_r;
      3'd6:    src_val_s = imm_r;
      default: begin
        src_val_s = WORD_ZERO;
        src_ok_s  = 1'b0;
      end
    endcase
  end

  // ALU result from X and Y, truncated to the word width.
  always_comb begin
    alu_s = WORD_ZERO;
    case (alu_r)
      3'd0:    alu_s = x_r + y_r;
      3'd1:    alu_s = x_r - y_r;
      3'd2:    alu_s = x_r & y_r;
      3'd3:    alu_s = x_r | y_r;
      3'd4:    alu_s = x_r ^ y_r;
      3'd5:    alu_s = ~x_r;
      3'd6:    alu_s = ($signed(x_r) < $signed(y_r)) ? WORD_ONE : WORD_ZERO;
      default: alu_s = x_r >> 1;
    endcase
  end

  // Sequencer, architectural registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      pc_r        <= WORD_ZERO;
      ir_r        <= WORD_ZERO;
      mar_r       <= WORD_ZERO;
      mdr_r       <= WORD_ZERO;
      x_r         <= WORD_ZERO;
      y_r         <= WORD_ZERO;
      z_r         <= WORD_ZERO;
      bus_r       <= WORD_ZERO;
      for (int i = 0; i < NREGS; i++) begin
        rf_r[i] <= WORD_ZERO;
      end
      op_r        <= OP_MOVE;
      src_r       <= 3'd0;
      dst_r       <= 3'd7;
      alu_r       <= 3'd0;
      reg_r       <= '0;
      imm_r       <= WORD_ZERO;
      pcinc_r     <= 1'b0;
      cnt_r       <= CNT_ZERO;
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= WORD_ZERO;
      mem_wdata_r <= WORD_ZERO;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (io.uop_valid) begin
            op_r    <= io.uop_op;
            src_r   <= io.uop_src;
            dst_r   <= io.uop_dst;
            alu_r   <= io.uop_alu;
            reg_r   <= io.uop_reg;
            imm_r   <= io.uop_imm;
            pcinc_r <= io.uop_pcinc;
            cnt_r   <= CNT_ZERO;
            ready_r <= 1'b0;
            if ((io.uop_op == OP_MEMRD) || (io.uop_op == OP_MEMWR)) begin
              state_r     <= ST_MEM;
              mem_req_r   <= 1'b1;
              mem_we_r    <= (io.uop_op == OP_MEMWR);
              mem_addr_r  <= mar_r;
              mem_wdata_r <= mdr_r;
            end else begin
              state_r <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          state_r <= ST_DONE;
          done_r  <= 1'b1;
          if (op_r == OP_ALU) begin
            z_r <= alu_s;
            if (pcinc_r) pc_r <= pc_inc_s;
          end else if (!src_ok_s) begin
            err_r <= 1'b1;
          end else begin
            bus_r <= src_val_s;
            if (pcinc_r) pc_r <= pc_inc_s;
            // A PC destination is assigned last so it wins over the increment.
            case (dst_r)
              3'd0:    pc_r         <= src_val_s;
              3'd1:    ir_r         <= src_val_s;
              3'd2:    mar_r        <= src_val_s;
              3'd3:    mdr_r        <= src_val_s;
              3'd4:    x_r          <= src_val_s;
              3'd5:    y_r          <= src_val_s;
              3'd6:    rf_r[reg_r]  <= src_val_s;
              default: ;
            endcase
          end
        end
        ST_MEM: begin
          if (io.mem_ack) begin
            if (op_r == OP_MEMRD) mdr_r <= io.mem_rdata;
            state_r   <= ST_DONE;
            done_r    <= 1'b1;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            if (pcinc_r) pc_r <= pc_inc_s;
          end else if (cnt_r == CNT_LAST) begin
            err_r     <= 1'b1;
            state_r   <= ST_DONE;
            done_r    <= 1'b1;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            if (pcinc_r) pc_r <= pc_inc_s;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
        end
        default: begin
          state_r   <= ST_IDLE;
          ready_r   <= 1'b1;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
        end
      endcase
    end
  end

  assign io.uop_ready = ready_r;
  assign io.mem_req   = mem_req_r;
  assign io.mem_we    = mem_we_r;
  assign io.mem_addr  = mem_addr_r;
  assign io.mem_wdata = mem_wdata_r;
  assign io.done      = done_r;
  assign io.err       = err_r;
  assign io.pc        = pc_r;
  assign io.ir        = ir_r;
  assign io.bus       = bus_r;
endmodule

// File: tb/tb_bus_datapath.sv
// Directed plus randomized micro-op sequences for bus_datapath, checked against
// an architectural model of the register state kept in the bench.
module tb_bus_datapath;
  localparam int W       = 16;
  localparam int NR      = 64;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [15:0] m_pc, m_ir, m_mar, m_mdr, m_x, m_y, m_z, m_bus;
  logic        m_err;
  logic [15:0] m_rf [NR];

  bus_datapath_if #(.WIDTH(W), .NREGS(NR)) dif ();

  bus_datapath #(.WIDTH(W), .NREGS(NR), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (dif)
  );

  always #5 clk = ~clk;

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0; m_ir = 16'h0; m_mar = 16'h0; m_mdr = 16'h0;
    m_x = 16'h0; m_y = 16'h0; m_z = 16'h0; m_bus = 16'h0; m_err = 1'b0;
    for (int i = 0; i < NR; i++) m_rf[i] = 16'h0;
  endtask

  function automatic logic [15:0] alu_model(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    int ia, ib, sa, sb, r;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 32768) ? ia - 65536 : ia;
    sb = (ib >= 32768) ? ib - 65536 : ib;
    case (f)
      3'd0:    r = (ia + ib) % 65536;
      3'd1:    r = (ia - ib + 65536) % 65536;
      3'd2:    r = ia & ib;
      3'd3:    r = ia | ib;
      3'd4:    r = ia ^ ib;
      3'd5:    r = 65535 - ia;
      3'd6:    r = (sa < sb) ? 1 : 0;
      default: r = ia / 2;
    endcase
    return 16'(r);
  endfunction

  function automatic logic [15:0] src_model(input logic [2:0] s, input logic [5:0] rg, input logic [15:0] imm);
    case (s)
      3'd0:    return m_pc;
      3'd1:    return m_mdr;
      3'd2:    return m_z;
      3'd3:    return m_rf[rg];
      3'd4:    return m_x;
      3'd5:    return m_y;
      default: return imm;
    endcase
  endfunction

  // wait_cyc: wait cycles before mem_ack (ack lands in MEM cycle wait_cyc+1); -1 means never.
  task automatic do_uop(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                        input logic [2:0] alu, input logic [5:0] rg, input logic [15:0] imm,
                        input logic pcinc, input int wait_cyc, input logic [15:0] rdata);
    int          n, req_cnt, exp_n, exp_req;
    bit          seen_done, is_mem, acked;
    logic        a;
    logic [15:0] v;
    is_mem = (op == 2'd2) || (op == 2'd3);
    acked  = is_mem && (wait_cyc >= 0) && (wait_cyc < TIMEOUT);
    @(negedge clk);
    check_b("ready_idle", dif.uop_ready, 1'b1);
    check_b("done_single", dif.done, 1'b0);
    dif.uop_valid = 1'b1; dif.uop_op = op; dif.uop_src = src; dif.uop_dst = dst;
    dif.uop_alu = alu; dif.uop_reg = rg; dif.uop_imm = imm; dif.uop_pcinc = pcinc;
    dif.mem_ack = 1'b0;
    @(posedge clk);
    n = 0; req_cnt = 0; seen_done = 1'b0;
    while (!seen_done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) check_b("ready_busy", dif.uop_ready, 1'b0);
      // Offer junk while busy: the datapath must neither accept it nor use it.
      dif.uop_valid = 1'b1; dif.uop_op = 2'($urandom); dif.uop_src = 3'($urandom);
      dif.uop_dst = 3'($urandom); dif.uop_alu = 3'($urandom); dif.uop_reg = 6'($urandom);
      dif.uop_imm = 16'($urandom); dif.uop_pcinc = 1'($urandom);
      if (dif.done) begin
        seen_done = 1'b1;
        dif.uop_valid = 1'b0;
        dif.mem_ack = 1'b0;
      end else begin
        if (dif.mem_req) begin
          req_cnt++;
          check_w("mem_addr", dif.mem_addr, m_mar);
          check_w("mem_wdata", dif.mem_wdata, m_mdr);
          check_b("mem_we", dif.mem_we, op == 2'd3);
        end
        a = is_mem && (wait_cyc >= 0) && (n == wait_cyc + 1);
        dif.mem_ack = a;
        dif.mem_rdata = a ? rdata : 16'($urandom);
      end
    end
    check_b("done_seen", seen_done, 1'b1);
    exp_n   = !is_mem ? 2 : (acked ? wait_cyc + 2 : TIMEOUT + 1);
    exp_req = !is_mem ? 0 : (acked ? wait_cyc + 1 : TIMEOUT);
    check_w("latency", 16'(n), 16'(exp_n));
    check_w("req_cycles", 16'(req_cnt), 16'(exp_req));

    if (op == 2'd0) begin
      if (src == 3'd7) begin
        m_err = 1'b1;
      end else begin
        v = src_model(src, rg, imm);
        m_bus = v;
        if (pcinc) m_pc = m_pc + 16'd1;
        case (dst)
          3'd0:    m_pc = v;
          3'd1:    m_ir = v;
          3'd2:    m_mar = v;
          3'd3:    m_mdr = v;
          3'd4:    m_x = v;
          3'd5:    m_y = v;
          3'd6:    m_rf[rg] = v;
          default: ;
        endcase
      end
    end else if (op == 2'd1) begin
      m_z = alu_model(alu, m_x, m_y);
      if (pcinc) m_pc = m_pc + 16'd1;
    end else begin
      if (acked) begin
        if (op == 2'd2) m_mdr = rdata;
      end else begin
        m_err = 1'b1;
      end
      if (pcinc) m_pc = m_pc + 16'd1;
    end
    check_w("pc", dif.pc, m_pc);
    check_w("ir", dif.ir, m_ir);
    check_w("bus", dif.bus, m_bus);
    check_b("err", dif.err, m_err);
  endtask

  task automatic mov(input logic [2:0] src, input logic [2:0] dst, input logic [5:0] rg,
                     input logic [15:0] imm, input logic pcinc);
    do_uop(2'd0, src, dst, 3'd0, rg, imm, pcinc, -1, 16'h0);
  endtask

  task automatic alu_op(input logic [2:0] f, input logic pcinc);
    do_uop(2'd1, 3'd0, 3'd0, f, 6'd0, 16'h0, pcinc, -1, 16'h0);
  endtask

  task automatic mem_op(input logic [1:0] op, input int wait_cyc, input logic [15:0] rdata);
    do_uop(op, 3'd0, 3'd0, 3'd0, 6'd0, 16'h0, 1'b0, wait_cyc, rdata);
  endtask

  initial begin
    int w;
    reset = 1'b1;
    dif.uop_valid = 1'b0; dif.uop_op = 2'd0; dif.uop_src = 3'd0; dif.uop_dst = 3'd7;
    dif.uop_alu = 3'd0; dif.uop_reg = 6'd0; dif.uop_imm = 16'h0; dif.uop_pcinc = 1'b0;
    dif.mem_ack = 1'b0; dif.mem_rdata = 16'h0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_b("rst_ready", dif.uop_ready, 1'b1);
    check_b("rst_done", dif.done, 1'b0);
    check_b("rst_mem_req", dif.mem_req, 1'b0);
    check_b("rst_mem_we", dif.mem_we, 1'b0);
    check_w("rst_mem_addr", dif.mem_addr, 16'h0);
    check_w("rst_mem_wdata", dif.mem_wdata, 16'h0);
    check_w("rst_pc", dif.pc, 16'h0);
    check_b("rst_err", dif.err, 1'b0);

    // Immediate to register file and back into X.
    mov(3'd6, 3'd6, 6'd5, 16'h1234, 1'b0);
    mov(3'd3, 3'd4, 6'd5, 16'h0, 1'b0);
    check_w("x_from_reg5", dif.bus, 16'h1234);
    mov(3'd4, 3'd7, 6'd0, 16'h0, 1'b0);
    check_w("x_readback", dif.bus, 16'h1234);

    // ALU boundaries: signed overflow on add, signed less-than, borrow on subtract.
    mov(3'd6, 3'd4, 6'd0, 16'h7FFF, 1'b0);
    mov(3'd6, 3'd5, 6'd0, 16'h0001, 1'b0);
    alu_op(3'd0, 1'b0);
    mov(3'd2, 3'd7, 6'd0, 16'h0, 1'b0);
    check_w("alu_add", dif.bus, 16'h8000);
    mov(3'd6, 3'd4, 6'd0, 16'hFFFF, 1'b0);
    mov(3'd6, 3'd5, 6'd0, 16'h0000, 1'b0);
    alu_op(3'd6, 1'b0);
    mov(3'd2, 3'd7, 6'd0, 16'h0, 1'b0);
    check_w("alu_slt", dif.bus, 16'h0001);
    mov(3'd6, 3'd4, 6'd0, 16'h0000, 1'b0);
    mov(3'd6, 3'd5, 6'd0, 16'h0001, 1'b0);
    alu_op(3'd1, 1'b0);
    mov(3'd2, 3'd7, 6'd0, 16'h0, 1'b0);
    check_w("alu_sub", dif.bus, 16'hFFFF);

    // Memory read acknowledged after three wait cycles.
    mov(3'd6, 3'd2, 6'd0, 16'h0040, 1'b0);
    mov(3'd6, 3'd3, 6'd0, 16'h5555, 1'b0);
    mem_op(2'd2, 3, 16'hBEEF);
    mov(3'd1, 3'd7, 6'd0, 16'h0, 1'b0);
    check_w("mdr_beef", dif.bus, 16'hBEEF);

    // Acknowledge in the last allowed cycle still succeeds.
    mem_op(2'd3, TIMEOUT - 1, 16'h0);
    check_b("ack_last_ok", dif.err, 1'b0);

    // PC wrap on increment, and MOVE to PC overriding the increment.
    mov(3'd6, 3'd0, 6'd0, 16'hFFFF, 1'b0);
    alu_op(3'd2, 1'b1);
    check_w("pc_wrap", dif.pc, 16'h0000);
    mov(3'd6, 3'd0, 6'd0, 16'h0100, 1'b1);
    check_w("pc_override", dif.pc, 16'h0100);

    // Write never acknowledged: timeout, sticky error, MDR untouched.
    mem_op(2'd3, -1, 16'h0);
    check_b("timeout_err", dif.err, 1'b1);
    mov(3'd1, 3'd7, 6'd0, 16'h0, 1'b0);
    check_w("mdr_kept", dif.bus, 16'hBEEF);

    // Reset while waiting for memory.
    @(negedge clk);
    dif.uop_valid = 1'b1; dif.uop_op = 2'd2; dif.uop_pcinc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.uop_valid = 1'b0; dif.mem_ack = 1'b0;
    @(negedge clk);
    check_b("pre_rst_req", dif.mem_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_b("midrst_mem_req", dif.mem_req, 1'b0);
    check_b("midrst_ready", dif.uop_ready, 1'b1);
    check_w("midrst_pc", dif.pc, 16'h0);
    check_w("midrst_ir", dif.ir, 16'h0);
    check_w("midrst_bus", dif.bus, 16'h0);
    check_b("midrst_err", dif.err, 1'b0);
    mov(3'd4, 3'd7, 6'd0, 16'h0, 1'b0);
    mov(3'd5, 3'd7, 6'd0, 16'h0, 1'b0);
    mov(3'd2, 3'd7, 6'd0, 16'h0, 1'b0);
    mov(3'd1, 3'd7, 6'd0, 16'h0, 1'b0);
    mov(3'd3, 3'd7, 6'd5, 16'h0, 1'b0);
    check_w("midrst_reg5", dif.bus, 16'h0);
    mem_op(2'd2, 0, 16'hA5A5);

    // Illegal source: error, no update, no increment, completion still signalled.
    mov(3'd7, 3'd4, 6'd0, 16'hDEAD, 1'b1);
    check_b("illegal_err", dif.err, 1'b1);
    mov(3'd4, 3'd7, 6'd0, 16'h0, 1'b0);
    check_w("illegal_no_x", dif.bus, 16'h0);

    // Randomized micro-op stream.
    for (int k = 0; k < 80; k++) begin
      w = $urandom_range(0, TIMEOUT + 1);
      if (w == TIMEOUT + 1) w = -1;
      do_uop(2'($urandom_range(0, 3)),
             ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6)),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             6'($urandom_range(0, 7)), 16'($urandom), 1'($urandom), w, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_datapath.md
BUS_DATAPATH -- requirements
Module: bus_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data/address word width in bits (>=8).
REQ-002 SHALL have parameter NREGS, default 64, meaning register-file depth (power of two, >=2); RSEL = log2(NREGS).
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning maximum cycles waited for mem_ack (>=1).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-005 SHALL have ports: uop_valid  in  1  micro-op offered; uop_ready  out  1  micro-op accepted when valid&ready at a rising edge.
REQ-006 SHALL have ports: uop_op  in  2  0 MOVE, 1 ALU, 2 MEMRD, 3 MEMWR; uop_src  in  3  bus source; uop_dst  in  3  bus destination; uop_alu  in  3  ALU function; uop_reg  in  RSEL  register index; uop_imm  in  WIDTH  immediate; uop_pcinc  in  1  increment PC on completion.
REQ-007 SHALL have ports: mem_req  out  1; mem_we  out  1; mem_addr  out  WIDTH; mem_wdata  out  WIDTH; mem_rdata  in  WIDTH; mem_ack  in  1.
REQ-008 SHALL have ports: done  out  1  one-cycle completion pulse; err  out  1  sticky error; pc  out  WIDTH; ir  out  WIDTH; bus  out  WIDTH  last value driven on internal bus.

Function
REQ-009 SHALL hold internal registers PC, IR, MAR, MDR, X, Y, Z (WIDTH each) and an NREGS x WIDTH register file.
REQ-010 SHALL decode src: 0 PC, 1 MDR, 2 Z, 3 REG[uop_reg], 4 X, 5 Y, 6 uop_imm, 7 illegal; dst: 0 PC, 1 IR, 2 MAR, 3 MDR, 4 X, 5 Y, 6 REG[uop_reg], 7 none.
REQ-011 SHALL implement FSM IDLE, EXEC, MEM, DONE; uop_ready=1 only in IDLE; accepted fields latched at acceptance edge.
REQ-012 SHALL, on acceptance in IDLE: MOVE/ALU -> EXEC; MEMRD/MEMWR -> MEM.
REQ-013 SHALL, in EXEC, for MOVE: drive exactly one source onto bus, write dst and the bus output register at the edge ending EXEC; go DONE.
REQ-014 SHALL, in EXEC, for ALU: Z <= f(X,Y) at the edge ending EXEC, f = 0 X+Y, 1 X-Y, 2 X&Y, 3 X|Y, 4 X^Y, 5 ~X, 6 signed X<Y ? 1 : 0, 7 X>>1 logical; all results truncated to WIDTH; go DONE.
REQ-015 SHALL, in MEM, hold mem_req=1, mem_addr=MAR, mem_we=(op==MEMWR), mem_wdata=MDR; outputs stable until ack or timeout.
REQ-016 SHALL, on mem_ack sampled high in MEM: for MEMRD MDR <= mem_rdata at that edge; drop mem_req next cycle; go DONE.
REQ-017 SHALL count MEM cycles; if TIMEOUT cycles elapse without mem_ack, go DONE, set err, leave MDR unchanged; mem_ack in the TIMEOUT-th cycle counts as success.
REQ-018 SHALL assert done for exactly the DONE cycle, then return to IDLE; latency acceptance-edge to done = 2 cycles for MOVE/ALU, ack-wait + 2 for memory ops; peak throughput one uop per 3 cycles.
REQ-019 SHALL, if uop_pcinc=1, PC <= PC+1 (mod 2^WIDTH) at the edge entering DONE; a MOVE with dst PC in the same uop overrides the increment.
REQ-020 SHALL treat src=7 on MOVE as illegal: no register updated, no pcinc, err set, done still pulsed.
REQ-021 SHALL ignore uop_src/uop_dst for ALU and memory ops; MOVE with dst=7 updates only bus.
REQ-022 SHALL keep err high once set until reset; err does not block further uops.
REQ-023 SHALL ignore uop_valid in any state other than IDLE.

Reset
REQ-024 SHALL, on reset high at a rising edge, clear PC, IR, MAR, MDR, X, Y, Z, bus, all register-file entries, timeout counter and err to 0, and enter IDLE.
REQ-025 SHALL drive after reset: uop_ready=1, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-026 SHALL, on reset mid-operation (EXEC or MEM), abandon the uop with no destination update and deassert mem_req the following cycle.

Verification
REQ-027 SHALL cover MOVE imm 0x1234 -> REG[5], then MOVE REG[5] -> X: X=0x1234, bus=0x1234, done 2 cycles after each acceptance.
REQ-028 SHALL cover ALU: X=0x7FFF, Y=0x0001, op ADD -> Z=0x8000; op SLT with X=0xFFFF, Y=0 -> Z=1; op SUB 0-1 -> Z=0xFFFF.
REQ-029 SHALL cover MEMRD with MAR=0x0040, ack after 3 wait cycles, rdata=0xBEEF -> MDR=0xBEEF, mem_req high exactly 4 cycles, err=0.
REQ-030 SHALL cover MEMWR with ack never asserted -> mem_req drops after TIMEOUT cycles, err=1, MDR unchanged, done pulsed once.
REQ-031 SHALL cover PC=0xFFFF with uop_pcinc=1 -> PC=0x0000; MOVE imm 0x0100 -> PC with pcinc=1 -> PC=0x0100.
REQ-032 SHALL cover reset asserted during MEM wait -> next cycle mem_req=0, uop_ready=1, all registers 0, err=0.
